// File: rtl/rst_seq_gen.sv
// -----------------------------------------------------------------------------
// rst_seq_gen
//
// Power-on / software reset sequencer. After power-up or rst_in it holds every
// downstream domain in reset for POR_CNT cycles. It then releases NUM_CH
// active-low reset channels one at a time, STAGGER cycles apart, with ch0
// released first. A software request seen while releasing or running restarts
// the sequence with the shorter SW_HOLD hold. rst_cause_o records which kind of
// event started the current sequence.
//
// Parameters
//   POR_CNT  hold length after power-up / rst_in (>= 2)
//   SW_HOLD  hold length after a software reset request (>= 2)
//   NUM_CH   number of reset channels (>= 1)
//   STAGGER  cycles between successive channel releases (>= 1)
//
// Ports
//   clk_in        in   1       system clock
//   rst_in        in   1       synchronous active-high reset, restarts full POR
//   sw_rst_req_i  in   1       software reset request, level-sampled each cycle
//   rst_n_o       out  NUM_CH  active-low channel resets, bit i released i-th
//   done_o        out  1       all channels released
//   rst_cause_o   out  2       01 = POR / rst_in, 10 = software
//
// Every output comes straight from a register. Registers carry declaration
// initialisers equal to their reset values so the block sequences correctly
// from power-up without any rst_in pulse.
// -----------------------------------------------------------------------------
module rst_seq_gen #(
    parameter int POR_CNT = 500_000,
    parameter int SW_HOLD = 16,
    parameter int NUM_CH  = 3,
    parameter int STAGGER = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              sw_rst_req_i,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic              done_o,
    output logic [1:0]        rst_cause_o
);

    localparam int MAX_HOLD = (POR_CNT > SW_HOLD) ? POR_CNT : SW_HOLD;
    localparam int CNT_W    = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam int SCNT_W   = $clog2(STAGGER) + 1;
    localparam int IDX_W    = $clog2(NUM_CH) + 1;

    // The hold register keeps hold_len-1 so it always fits the counter width,
    // even when the longest hold is an exact power of two.
    localparam logic [CNT_W-1:0]  POR_LAST = CNT_W'(POR_CNT - 1);
    localparam logic [CNT_W-1:0]  SW_LAST  = CNT_W'(SW_HOLD - 1);
    localparam logic [SCNT_W-1:0] STG_LAST = SCNT_W'(STAGGER - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);

    localparam logic [1:0] ST_HOLD    = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    localparam logic [1:0] CAUSE_POR = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    // Parameter sanity checks, reported while the design is elaborated.
    if (POR_CNT < 2) begin : g_bad_por_cnt
        $error("rst_seq_gen: POR_CNT (%0d) must be >= 2", POR_CNT);
    end
    if (SW_HOLD < 2) begin : g_bad_sw_hold
        $error("rst_seq_gen: SW_HOLD (%0d) must be >= 2", SW_HOLD);
    end
    if (NUM_CH < 1) begin : g_bad_num_ch
        $error("rst_seq_gen: NUM_CH (%0d) must be >= 1", NUM_CH);
    end
    if (STAGGER < 1) begin : g_bad_stagger
        $error("rst_seq_gen: STAGGER (%0d) must be >= 1", STAGGER);
    end

    logic [1:0]        state_q     = ST_HOLD;
    logic [CNT_W-1:0]  cnt_q       = '0;
    logic [CNT_W-1:0]  hold_last_q = POR_LAST;
    logic [SCNT_W-1:0] scnt_q      = '0;
    logic [IDX_W-1:0]  idx_q       = '0;
    logic [NUM_CH-1:0] rst_n_q     = '0;
    logic              done_q      = 1'b0;
    logic [1:0]        cause_q     = CAUSE_POR;

    logic [1:0]        state_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [CNT_W-1:0]  hold_last_d;
    logic [SCNT_W-1:0] scnt_d;
    logic [IDX_W-1:0]  idx_d;
    logic [NUM_CH-1:0] rst_n_d;
    logic              done_d;
    logic [1:0]        cause_d;

    logic [IDX_W-1:0]  idx_nxt;

    assign idx_nxt = idx_q + IDX_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_last_d = hold_last_q;
        scnt_d      = scnt_q;
        idx_d       = idx_q;
        rst_n_d     = rst_n_q;
        done_d      = done_q;
        cause_d     = cause_q;

        case (state_q)
            ST_HOLD: begin
                // Software requests are deliberately not looked at here: an
                // active hold always runs to its programmed length.
                if (cnt_q == hold_last_q) begin
                    rst_n_d = NUM_CH'(1);
                    scnt_d  = '0;
                    idx_d   = '0;
                    if (NUM_CH == 1) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (sw_rst_req_i) begin
                    state_d     = ST_HOLD;
                    cnt_d       = '0;
                    hold_last_d = SW_LAST;
                    rst_n_d     = '0;
                    done_d      = 1'b0;
                    cause_d     = CAUSE_SW;
                end else if (scnt_q == STG_LAST) begin
                    idx_d  = idx_nxt;
                    scnt_d = '0;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (idx_nxt == IDX_W'(i)) begin
                            rst_n_d[i] = 1'b1;
                        end
                    end
                    // The last channel and done_o go high on the same edge.
                    if (idx_nxt == IDX_LAST) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end
                end else begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end

            ST_RUN: begin
                if (sw_rst_req_i) begin
                    state_d     = ST_HOLD;
                    cnt_d       = '0;
                    hold_last_d = SW_LAST;
                    rst_n_d     = '0;
                    done_d      = 1'b0;
                    cause_d     = CAUSE_SW;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a full power-on hold.
                state_d     = ST_HOLD;
                cnt_d       = '0;
                hold_last_d = POR_LAST;
                rst_n_d     = '0;
                done_d      = 1'b0;
                cause_d     = CAUSE_POR;
            end
        endcase
    end

    // rst_in outranks everything, including a simultaneous software request.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            hold_last_q <= POR_LAST;
            scnt_q      <= '0;
            idx_q       <= '0;
            rst_n_q     <= '0;
            done_q      <= 1'b0;
            cause_q     <= CAUSE_POR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_last_q <= hold_last_d;
            scnt_q      <= scnt_d;
            idx_q       <= idx_d;
            rst_n_q     <= rst_n_d;
            done_q      <= done_d;
            cause_q     <= cause_d;
        end
    end

    assign rst_n_o     = rst_n_q;
    assign done_o      = done_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// -----------------------------------------------------------------------------
// Bench for rst_seq_gen. u_dut0 uses POR_CNT=8, SW_HOLD=3, NUM_CH=3,
// STAGGER=4 and is driven from a per-cycle vector table. u_dut1 uses NUM_CH=1,
// STAGGER=1 and is only powered up, never reset.
// -----------------------------------------------------------------------------
module tb_rst_seq_gen;

    typedef struct {
        logic       rst;
        logic       sw;
        logic [2:0] rst_n;
        logic       done;
        logic [1:0] cause;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst0 = 1'b0;
    logic       sw0 = 1'b0;
    logic [2:0] rst_n0;
    logic       done0;
    logic [1:0] cause0;

    logic       rst1 = 1'b0;
    logic       sw1 = 1'b0;
    logic [0:0] rst_n1;
    logic       done1;
    logic [1:0] cause1;

    int total = 0;
    int bad   = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rst_seq_gen #(.POR_CNT(8), .SW_HOLD(3), .NUM_CH(3), .STAGGER(4)) u_dut0 (
        .clk_in      (clk),
        .rst_in      (rst0),
        .sw_rst_req_i(sw0),
        .rst_n_o     (rst_n0),
        .done_o      (done0),
        .rst_cause_o (cause0)
    );

    rst_seq_gen #(.POR_CNT(8), .SW_HOLD(3), .NUM_CH(1), .STAGGER(1)) u_dut1 (
        .clk_in      (clk),
        .rst_in      (rst1),
        .sw_rst_req_i(sw1),
        .rst_n_o     (rst_n1),
        .done_o      (done1),
        .rst_cause_o (cause1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic [2:0] n,
                       input logic d, input logic [1:0] c, input int rep);
        vec_t v;
        v.rst = r; v.sw = s; v.rst_n = n; v.done = d; v.cause = c;
        for (int i = 0; i < rep; i++) vecs.push_back(v);
    endtask

    // Expected outputs for the 8-cycle hold and 4-cycle stagger following E0.
    // hold_sw drives sw_rst_req_i for all HOLD-sampled edges (must be ignored).
    task automatic por_tail(input logic hold_sw, input logic [1:0] c);
        add(1'b0, hold_sw, 3'b000, 1'b0, c, 7);
        add(1'b0, hold_sw, 3'b001, 1'b0, c, 1);
        add(1'b0, 1'b0,    3'b001, 1'b0, c, 3);
        add(1'b0, 1'b0,    3'b011, 1'b0, c, 4);
        add(1'b0, 1'b0,    3'b111, 1'b1, c, 3);
    endtask

    initial begin
        int n;
        int first0;

        // A: power-up with no rst_in
        por_tail(1'b0, 2'b01);
        // B: rst_in held for two edges
        add(1'b1, 1'b0, 3'b000, 1'b0, 2'b01, 2);
        por_tail(1'b0, 2'b01);
        // C: one-cycle software request in RUN
        add(1'b0, 1'b1, 3'b000, 1'b0, 2'b10, 1);
        add(1'b0, 1'b0, 3'b000, 1'b0, 2'b10, 2);
        add(1'b0, 1'b0, 3'b001, 1'b0, 2'b10, 4);
        add(1'b0, 1'b0, 3'b011, 1'b0, 2'b10, 4);
        add(1'b0, 1'b0, 3'b111, 1'b1, 2'b10, 3);
        // D: rst_in mid-RELEASE, then software requests held through the POR hold
        add(1'b0, 1'b1, 3'b000, 1'b0, 2'b10, 1);
        add(1'b0, 1'b0, 3'b000, 1'b0, 2'b10, 2);
        add(1'b0, 1'b0, 3'b001, 1'b0, 2'b10, 4);
        add(1'b0, 1'b0, 3'b011, 1'b0, 2'b10, 1);
        add(1'b1, 1'b0, 3'b000, 1'b0, 2'b01, 1);
        por_tail(1'b1, 2'b01);
        // E: rst_in and sw together in RUN, rst_in wins
        add(1'b1, 1'b1, 3'b000, 1'b0, 2'b01, 1);
        por_tail(1'b0, 2'b01);

        // Power-up state before any clock edge
        #1;
        check("init rst_n", 32'(rst_n0), 32'(3'b000));
        check("init done", 32'(done0), 32'(1'b0));
        check("init cause", 32'(cause0), 32'(2'b01));

        for (int k = 0; k < vecs.size(); k++) begin
            rst0 = vecs[k].rst;
            sw0  = vecs[k].sw;
            @(posedge clk);
            #1;
            check($sformatf("v%0d rst_n", k), 32'(rst_n0), 32'(vecs[k].rst_n));
            check($sformatf("v%0d done", k), 32'(done0), 32'(vecs[k].done));
            check($sformatf("v%0d cause", k), 32'(cause0), 32'(vecs[k].cause));
            // Single-channel instance: channel and done both rise at edge 8
            if (k < 18) begin
                check($sformatf("ch1 e%0d rst_n", k + 1), 32'(rst_n1), ((k + 1) >= 8) ? 32'd1 : 32'd0);
                check($sformatf("ch1 e%0d done", k + 1), 32'(done1), ((k + 1) >= 8) ? 32'd1 : 32'd0);
                check($sformatf("ch1 e%0d cause", k + 1), 32'(cause1), 32'(2'b01));
            end
        end
        rst0 = 1'b0;
        sw0  = 1'b0;

        // Software request from RUN: ch0 at +3, done at +11, bounded wait
        sw0 = 1'b1;
        @(posedge clk);
        #1;
        sw0 = 1'b0;
        check("sw edge rst_n", 32'(rst_n0), 32'(3'b000));
        n = 0;
        first0 = -1;
        while (!done0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (rst_n0[0] && first0 < 0) first0 = n;
        end
        check("sw ch0 latency", 32'(first0), 32'd3);
        check("sw done latency", 32'(n), 32'd11);
        check("sw final rst_n", 32'(rst_n0), 32'(3'b111));
        check("sw final cause", 32'(cause0), 32'(2'b10));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
